// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the byte-strobe merge used by register writes.
// Pure types and functions; no timing or flow control of its own.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_slave_regs_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) between a fabric master and a register completer.
// Plain wires; all latency and backpressure live in the endpoints.
interface axil_slave_regs_if #(
  parameter int ADDR_W = 8
);
  import axil_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  resp_t             bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  resp_t             rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_slave_regs.sv
// AXI4-Lite register bank, index 0 = read-only ID; write commits one cycle after both AW and W held,
// read data one cycle after AR; one outstanding each, B/R held until accepted. Option: AXIL_SLV_DECERR_EN.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          NREG     = 8,
  parameter logic [31:0] ID_VALUE = 32'h5249_5343
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  axil_slave_regs_if.slave     bus,
  output logic [NREG*32-1:0]   o_regs,
  output logic [NREG-1:0]      o_wr_pulse
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

`ifdef AXIL_SLV_DECERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              bvalid_q;
  resp_t             bresp_q;
  logic              rvalid_q;
  resp_t             rresp_q;
  logic [31:0]       rdata_q;
  logic [31:0]       regs_q [NREG];

  logic [IDX_W-1:0]  ar_idx;
  logic              aw_in_range;
  logic              ar_in_range;
  logic [SEL_W-1:0]  aw_sel;
  logic [SEL_W-1:0]  ar_sel;
  logic              unused_addr_lsbs;

  assign ar_idx           = bus.araddr[ADDR_W-1:2];
  assign aw_in_range      = int'(aw_idx) < NREG;
  assign ar_in_range      = int'(ar_idx) < NREG;
  assign aw_sel           = aw_idx[SEL_W-1:0];
  assign ar_sel           = ar_idx[SEL_W-1:0];
  assign unused_addr_lsbs = ^{bus.awaddr[1:0], bus.araddr[1:0]};

  assign bus.awready = !aw_held && !bvalid_q;
  assign bus.wready  = !w_held && !bvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = !rvalid_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      o_wr_pulse <= '0;
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else begin
      o_wr_pulse <= '0;
      if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
      if (bus.awvalid && bus.awready) begin
        aw_held <= 1'b1;
        aw_idx  <= bus.awaddr[ADDR_W-1:2];
      end
      if (bus.wvalid && bus.wready) begin
        w_held  <= 1'b1;
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
      // Both halves held: commit; new AW/W cannot arrive this cycle since both readies are low.
      if (aw_held && w_held) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= aw_in_range ? RESP_OKAY : OOR_RESP;
        if (aw_in_range && aw_idx != '0) begin
          regs_q[aw_sel]     <= strb_merge(regs_q[aw_sel], wdata_q, wstrb_q);
          o_wr_pulse[aw_sel] <= 1'b1;
        end
      end
    end
  end

  // Reads sample regs_q before any same-edge commit lands, so they return the pre-write value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (rvalid_q && bus.rready) rvalid_q <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        rvalid_q <= 1'b1;
        rresp_q  <= ar_in_range ? RESP_OKAY : OOR_RESP;
        if (!ar_in_range)       rdata_q <= '0;
        else if (ar_idx == '0)  rdata_q <= ID_VALUE;
        else                    rdata_q <= regs_q[ar_sel];
      end
    end
  end

  always_comb begin
    o_regs = '0;
    for (int k = 0; k < NREG; k++) begin
      o_regs[32*k +: 32] = (k == 0) ? ID_VALUE : regs_q[k];
    end
  end

endmodule

// File: tb/tb_axil_slave_regs.sv
// Directed bench for axil_slave_regs: a transaction-level model checked every cycle on the
// falling edge, plus hand-computed literal checks after each directed access.
module tb_axil_slave_regs;
  import axil_pkg::*;

  localparam int          ADDR_W = 8;
  localparam int          NREG   = 8;
  localparam logic [31:0] ID     = 32'h5249_5343;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0]  OOR    = 2'b10;
`else
  localparam logic [1:0]  OOR    = 2'b00;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREG*32-1:0]   regs;
  logic [NREG-1:0]      wr_pulse;
  int                   n_cmp = 0;
  int                   n_err = 0;

  axil_slave_regs_if #(.ADDR_W(ADDR_W)) bus();

  axil_slave_regs #(.ADDR_W(ADDR_W), .NREG(NREG), .ID_VALUE(ID)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_regs     (regs),
    .o_wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake never arrived within budget", name);
  endtask

  // Transaction-level model: accepted halves wait in queues, a complete pair commits one
  // cycle later, responses stay up until the bench accepts them.
  logic [31:0]       m_regs [NREG];
  logic [ADDR_W-1:0] aw_q [$];
  logic [31:0]       wd_q [$];
  logic [3:0]        ws_q [$];
  logic              m_bvalid, m_rvalid;
  logic [1:0]        m_bresp, m_rresp;
  logic [31:0]       m_rdata;
  logic [NREG-1:0]   m_pulse;
  bit                m_on = 1'b0;
  bit                aw_fire, w_fire, ar_fire;
  int                idx;
  logic [ADDR_W-1:0] c_a;
  logic [31:0]       c_d;
  logic [3:0]        c_s;

  always @(negedge clk) begin
    if (m_on) begin
      check("awready", bus.awready, aw_q.size() == 0 && !m_bvalid);
      check("wready", bus.wready, wd_q.size() == 0 && !m_bvalid);
      check("arready", bus.arready, !m_rvalid);
      check("bvalid", bus.bvalid, m_bvalid);
      check("rvalid", bus.rvalid, m_rvalid);
      check("wr_pulse", wr_pulse, m_pulse);
      if (m_bvalid) check("bresp", bus.bresp, m_bresp);
      if (m_rvalid) begin
        check("rdata", bus.rdata, m_rdata);
        check("rresp", bus.rresp, m_rresp);
      end
      for (int k = 0; k < NREG; k++) check($sformatf("reg%0d", k), regs[32*k +: 32], m_regs[k]);
    end
    if (rst) begin
      for (int k = 0; k < NREG; k++) m_regs[k] = (k == 0) ? ID : 32'h0;
      aw_q.delete(); wd_q.delete(); ws_q.delete();
      m_bvalid = 1'b0; m_rvalid = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00;
      m_rdata = 32'h0; m_pulse = '0;
      m_on = 1'b1;
    end else if (m_on) begin
      aw_fire = bus.awvalid && aw_q.size() == 0 && !m_bvalid;
      w_fire  = bus.wvalid && wd_q.size() == 0 && !m_bvalid;
      ar_fire = bus.arvalid && !m_rvalid;
      if (m_rvalid && bus.rready) m_rvalid = 1'b0;
      if (ar_fire) begin
        idx = int'(bus.araddr >> 2);
        m_rvalid = 1'b1;
        m_rresp  = (idx < NREG) ? 2'b00 : OOR;
        m_rdata  = (idx < NREG) ? m_regs[idx] : 32'h0;
      end
      m_pulse = '0;
      if (m_bvalid && bus.bready) m_bvalid = 1'b0;
      if (aw_q.size() != 0 && wd_q.size() != 0) begin
        c_a = aw_q.pop_front(); c_d = wd_q.pop_front(); c_s = ws_q.pop_front();
        idx = int'(c_a >> 2);
        m_bvalid = 1'b1;
        m_bresp  = (idx < NREG) ? 2'b00 : OOR;
        if (idx < NREG && idx != 0) begin
          for (int b = 0; b < 4; b++) if (c_s[b]) m_regs[idx][8*b +: 8] = c_d[8*b +: 8];
          m_pulse[idx] = 1'b1;
        end
      end
      if (aw_fire) aw_q.push_back(bus.awaddr);
      if (w_fire) begin wd_q.push_back(bus.wdata); ws_q.push_back(bus.wstrb); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [ADDR_W-1:0] a);
    int n = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready && n < 20) begin @(negedge clk); n++; end
    if (!bus.awready) timeout("aw_handshake");
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    @(negedge clk);
    while (!bus.wready && n < 20) begin @(negedge clk); n++; end
    if (!bus.wready) timeout("w_handshake");
    tick();
    bus.wvalid = 1'b0;
  endtask

  // Ends on the falling edge of the first cycle with bvalid high; lat counts cycles after W.
  task automatic wait_b(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.bvalid && lat < 20);
    if (!bus.bvalid) timeout("b_response");
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int gap, output int lat);
    send_aw(a);
    repeat (gap) tick();
    send_w(d, s);
    wait_b(lat);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    if (!bus.arready) timeout("ar_handshake");
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.rvalid) timeout("r_response");
    d = bus.rdata; r = bus.rresp;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [1:0]  rr;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_rresp", bus.rresp, 2'b00);
    check("reset_bresp", bus.bresp, 2'b00);
    check("reset_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("reset_reg1", regs[63:32], 32'h0);
    tick();

    do_read(8'h00, rd, rr);
    check("id_rdata", rd, 32'h5249_5343);
    check("id_rresp", rr, 2'b00);
    do_read(8'h0C, rd, rr);
    check("reg3_rdata", rd, 32'h0);

    do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 2, lat);
    check("b_latency", lat, 2);
    check("pulse_reg1", wr_pulse, 8'b0000_0010);
    check("regs_reg1", regs[63:32], 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    check("pulse_one_cycle", wr_pulse, 8'h00);
    tick();

    do_write(8'h08, 32'h1122_3344, 4'hF, 0, lat);
    tick();
    do_write(8'h0A, 32'hAABB_CCDD, 4'b0101, 0, lat);
    tick();
    do_read(8'h08, rd, rr);
    check("strobe_merge", rd, 32'h11BB_33DD);

    bus.bready = 1'b0;
    do_write(8'h0C, 32'h0000_00A5, 4'b0001, 0, lat);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", {bus.awready, bus.wready, bus.bvalid}, 3'b001);
      tick();
    end
    bus.bready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("release_ready", {bus.awready, bus.wready, bus.bvalid}, 3'b110);
    tick();

    do_write(8'h04, 32'hFFFF_FFFF, 4'b0000, 0, lat);
    check("zero_strb_pulse", wr_pulse, 8'b0000_0010);
    check("zero_strb_keep", regs[63:32], 32'hDEAD_BEEF);
    tick();

    do_write(8'h00, 32'h1234_5678, 4'hF, 0, lat);
    check("id_write_pulse", wr_pulse, 8'h00);
    check("id_write_bresp", bus.bresp, 2'b00);
    tick();

    do_read(8'h40, rd, rr);
    check("oor_rdata", rd, 32'h0);
    check("oor_rresp", rr, OOR);
    do_write(8'h40, 32'hFFFF_FFFF, 4'hF, 1, lat);
    check("oor_pulse", wr_pulse, 8'h00);
    check("oor_bresp", bus.bresp, OOR);
    tick();

    // Back-to-back reads with rready high: one per two cycles.
    for (int i = 0; i < 4; i++) begin
      bus.araddr = 8'(4 * i); bus.arvalid = 1'b1;
      tick();
    end
    bus.arvalid = 1'b0;
    repeat (2) tick();

    send_aw(8'h0C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_b", bus.bvalid, 1'b0);
      check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
      check("rst_reg3", regs[127:96], 32'h0);
      tick();
    end
    send_w(32'h0000_0077, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("w_alone_no_b", bus.bvalid, 1'b0);
      tick();
    end
    send_aw(8'h0C);
    wait_b(lat);
    check("late_aw_latency", lat, 2);
    check("late_aw_reg3", regs[127:96], 32'h0000_0077);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
